uart_cmd_dispatcher: RTL and testbench

Receive-side counterpart of the sensor-to-UART scheduler. Takes 16-bit command frames delivered by the UART receiver and queues them in a small FIFO. Routes each frame to exactly one of the 8 sensor controllers via a one-hot valid/taken handshake. Sits between `UART_RX` and the sensor controller bank; frame format matches the transmit side: [15:12] command, [11:7] address, [6:0] data.

---
 rtl/uart_cmd_dispatcher.sv | 128 ++++++++++++
 tb/tb_uart_cmd_dispatcher.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_dispatcher.sv
// Queues 16-bit command frames from the UART receiver and offers each one to a single
// sensor controller over a one-hot valid/taken handshake.
//   state | meaning
//   IDLE  | no offer outstanding; pop the FIFO head when one is queued
//   OFFER | cmd_valid/cmd_data held until taken or the offer timer expires
module uart_cmd_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx_done,
  input  logic [15:0]                   uart_rx_data,
  input  logic [7:0]                    sensor_taken,
  output logic [15:0]                   cmd_data,
  output logic [7:0]                    cmd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          bad_addr,
  output logic                          timeout,
  output logic                          state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [15:0]     head;
  logic [2:0]      sel_q, sel_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      valid_d;
  logic [15:0]     data_d;
  logic            pop, push, ovf_d, bad_d, timeout_d;

  assign head  = mem[rd_ptr];
  assign state = state_q;

  // A full FIFO still takes the incoming frame when the head leaves in the same cycle.
  assign push  = uart_rx_done && ((fifo_count != DEPTH_C) || pop);
  assign ovf_d = uart_rx_done && !push;

  always_comb begin
    state_d   = state_q;
    valid_d   = cmd_valid;
    data_d    = cmd_data;
    sel_d     = sel_q;
    timer_d   = timer_q;
    bad_d     = 1'b0;
    timeout_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          pop = 1'b1;
          if (head[11:10] != 2'b00) begin
            bad_d = 1'b1;
          end else begin
            data_d  = head;
            valid_d = 8'b1 << head[9:7];
            sel_d   = head[9:7];
            timer_d = TIMER_LOAD;
            state_d = OFFER;
          end
        end
      end
      OFFER: begin
        // Taken is checked first so an acceptance in the last offered cycle beats the timeout.
        if (sensor_taken[sel_q]) begin
          valid_d = '0;
          data_d  = '0;
          state_d = IDLE;
        end else if (timer_q == '0) begin
          valid_d   = '0;
          data_d    = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_valid  <= '0;
      cmd_data   <= '0;
      sel_q      <= '0;
      timer_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      bad_addr   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_valid <= valid_d;
      cmd_data  <= data_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      overflow  <= ovf_d;
      bad_addr  <= bad_d;
      timeout   <= timeout_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart_rx_data;
  end

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Randomized bench for uart_cmd_dispatcher: a queue-based reference model predicts every
// cycle's outputs and each offer; a negedge monitor compares the DUT against those queues.
module tb_uart_cmd_dispatcher;
  localparam int DEPTH = 4;
  localparam int TOC   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, uart_rx_done;
  logic [15:0]   uart_rx_data;
  logic [7:0]    sensor_taken;
  logic [15:0]   cmd_data;
  logic [7:0]    cmd_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow, bad_addr, timeout, state;

  uart_cmd_dispatcher #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
    .sensor_taken(sensor_taken), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .fifo_count(fifo_count), .overflow(overflow), .bad_addr(bad_addr),
    .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CW-1:0] cnt;
    logic [7:0]    v;
    logic [15:0]   d;
    logic          st, ovf, bad, to;
  } snap_t;
  typedef struct {
    int          cyc;
    logic [15:0] d;
  } ev_t;

  snap_t       snap_q[$];
  ev_t         ev_q[$];
  logic [15:0] mq[$];
  bit          m_off;
  int          m_age;
  logic [15:0] m_frame;
  int          cyc = 0;
  int          n_pass = 0, n_total = 0;
  logic [7:0]  prev_v = '0;
  snap_t       ms;
  ev_t         me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // Reference model: inputs just driven are sampled at the next edge; predict that cycle.
  task automatic model_step();
    snap_t       s;
    ev_t         e;
    bit          pop, ok;
    logic [15:0] f;
    s.cyc = cyc + 1;
    s.ovf = 1'b0; s.bad = 1'b0; s.to = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_off = 1'b0; m_age = 0; m_frame = '0;
    end else begin
      pop = !m_off && (mq.size() > 0);
      ok  = uart_rx_done && ((mq.size() < DEPTH) || pop);
      s.ovf = uart_rx_done && !ok;
      if (m_off) begin
        if (sensor_taken[m_frame[9:7]]) m_off = 1'b0;
        else if (m_age == TOC - 1) begin m_off = 1'b0; s.to = 1'b1; end
        else m_age++;
      end else if (pop) begin
        f = mq.pop_front();
        if (f[11:7] >= 5'd8) s.bad = 1'b1;
        else begin
          m_off = 1'b1; m_frame = f; m_age = 0;
          e.cyc = cyc + 1; e.d = f;
          ev_q.push_back(e);
        end
      end
      if (ok) mq.push_back(uart_rx_data);
    end
    s.cnt = CW'(mq.size());
    s.v   = m_off ? (8'b1 << m_frame[9:7]) : 8'h00;
    s.d   = m_off ? m_frame : 16'h0000;
    s.st  = m_off;
    snap_q.push_back(s);
  endtask

  task automatic drive(input logic r, input logic d, input logic [15:0] f, input logic [7:0] t);
    @(posedge clk); #1;
    rst_n = r; uart_rx_done = d; uart_rx_data = f; sensor_taken = t;
    model_step();
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wait_offer(input int age);
    int n = 0;
    while (!(m_off && m_age >= age) && n < 40) begin idle(); n++; end
    check("wait_offer", m_off && m_age >= age, 32'(m_age), 32'(age));
  endtask

  function automatic logic [15:0] good_frame();
    return {4'($urandom), 5'($urandom_range(0, 7)), 7'($urandom)};
  endfunction

  function automatic logic [15:0] any_frame();
    return {4'($urandom), 5'($urandom_range(0, 11)), 7'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
      ms = snap_q.pop_front();
      check("fifo_count", fifo_count == ms.cnt, 32'(fifo_count), 32'(ms.cnt));
      check("cmd_valid",  cmd_valid == ms.v,    32'(cmd_valid),  32'(ms.v));
      check("cmd_data",   cmd_data == ms.d,     32'(cmd_data),   32'(ms.d));
      check("state",      state == ms.st,       32'(state),      32'(ms.st));
      check("overflow",   overflow == ms.ovf,   32'(overflow),   32'(ms.ovf));
      check("bad_addr",   bad_addr == ms.bad,   32'(bad_addr),   32'(ms.bad));
      check("timeout",    timeout == ms.to,     32'(timeout),    32'(ms.to));
    end
    if (cmd_valid != 8'h00 && prev_v == 8'h00) begin
      check("offer_expected", ev_q.size() != 0, 32'(ev_q.size()), 32'd1);
      if (ev_q.size() != 0) begin
        me = ev_q.pop_front();
        check("offer_cycle", me.cyc == cyc, 32'(cyc), 32'(me.cyc));
        check("offer_data", cmd_data == me.d, 32'(cmd_data), 32'(me.d));
      end
    end
    prev_v = cmd_valid;
  end

  initial begin
    rst_n = 1'b0; uart_rx_done = 1'b0; uart_rx_data = '0; sensor_taken = '0;
    drive(1'b0, 1'b1, 16'($urandom), 8'hff);
    drive(1'b0, 1'b0, 16'($urandom), 8'hff);
    drive(1'b0, 1'b1, 16'($urandom), 8'hff);
    idle(); idle();

    // single frame, stray taken on controller 5, real taken 5 cycles into the offer
    drive(1'b1, 1'b1, 16'h3185, 8'h00);
    wait_offer(2); drive(1'b1, 1'b0, 16'h0000, 8'h20);
    wait_offer(5); drive(1'b1, 1'b0, 16'h0000, 8'h08);
    idle(); idle(); idle();

    // fill past capacity, then push into the full FIFO in the cycle it pops
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, good_frame(), 8'h00);
    wait_offer(0); drive(1'b1, 1'b0, 16'h0000, 8'b1 << m_frame[9:7]);
    drive(1'b1, 1'b1, good_frame(), 8'h00);
    for (int i = 0; i < 5; i++) begin
      wait_offer(0); drive(1'b1, 1'b0, 16'h0000, 8'b1 << m_frame[9:7]);
    end
    idle(); idle();

    // bad address followed by a frame to controller 0
    drive(1'b1, 1'b1, 16'h1480, 8'h00);
    drive(1'b1, 1'b1, 16'h5023, 8'h00);
    wait_offer(0); drive(1'b1, 1'b0, 16'h0000, 8'h01);
    idle(); idle();

    // full timeout, then taken in the final offered cycle
    drive(1'b1, 1'b1, 16'h2100, 8'h00);
    for (int i = 0; i < 14; i++) idle();
    drive(1'b1, 1'b1, 16'h2301, 8'h00);
    wait_offer(TOC - 1); drive(1'b1, 1'b0, 16'h0000, 8'h40);
    idle(); idle(); idle();

    // reset in the middle of an offer with frames still queued
    drive(1'b1, 1'b1, 16'h7080, 8'h00);
    drive(1'b1, 1'b1, good_frame(), 8'h00);
    drive(1'b1, 1'b1, good_frame(), 8'h00);
    wait_offer(1); drive(1'b0, 1'b0, 16'h0000, 8'h00);
    idle(); idle(); idle();

    for (int i = 0; i < 600; i++)
      drive(($urandom % 250) != 0, ($urandom % 3) == 0, any_frame(),
            8'($urandom & $urandom & $urandom));

    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 16'h0000, 8'hff);
    idle(); idle();
    @(posedge clk); @(negedge clk); #1;
    check("offers_left", ev_q.size() == 0, 32'(ev_q.size()), 32'd0);
    check("snaps_left", snap_q.size() == 0, 32'(snap_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
